// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 message padder: FSM encoding, block constants
// and the final-word byte mask / 0x80 terminator insertion.
package sha1_pkg;

   typedef enum logic [2:0] {
      ST_DATA   = 3'd0,
      ST_PAD    = 3'd1,
      ST_ZERO   = 3'd2,
      ST_LEN_HI = 3'd3,
      ST_LEN_LO = 3'd4
   } sha1_state_e;

   localparam logic [31:0] PAD_WORD    = 32'h8000_0000;
   localparam int          BLOCK_WORDS = 16;

   // Keeps the first nbytes bytes (big-endian), puts 0x80 right after them and
   // zeros the rest. A full 4-byte word has no room for the terminator.
   function automatic logic [31:0] pad_last_word(input logic [31:0] data,
                                                 input logic [2:0]  nbytes);
      logic [31:0] w;
      case (nbytes)
         3'd0:    w = PAD_WORD;
         3'd1:    w = {data[31:24], 8'h80, 16'h0000};
         3'd2:    w = {data[31:16], 8'h80, 8'h00};
         3'd3:    w = {data[31:8], 8'h80};
         default: w = data;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sha1_pad.sv
// SHA-1 message padder: streams message words through unchanged, then appends the
// 0x80 terminator, zero fill and the 64-bit big-endian bit length per 512-bit block.
module sha1_pad
   import sha1_pkg::*;
#(
   parameter int LEN_WIDTH = 64
) (
   input  logic        wb_clk_i,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   input  logic [2:0]  in_bytes,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_blk_last,
   output logic        out_msg_last,
   output logic        busy,
   output sha1_state_e dbg_state_o
);

   // Handshake: a word moves on a port only in a cycle where its valid and ready
   // are both high; valid never waits on ready, and out_data holds while stalled.

   localparam int          BCNT_W      = LEN_WIDTH - 3;
   localparam logic [3:0]  WCNT_LEN_HI = 4'(BLOCK_WORDS - 2);
   localparam logic [3:0]  WCNT_LAST   = 4'(BLOCK_WORDS - 1);

   sha1_state_e        state_q, state_d;
   logic [3:0]         wcnt_q, wcnt_d;
   logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
   logic               busy_q, busy_d;

   logic [3:0]           wcnt_inc;
   logic [LEN_WIDTH-1:0] len_bits;
   logic [63:0]          len64;

   assign wcnt_inc = wcnt_q + 4'd1;
   assign len_bits = {bcnt_q, 3'b000};
   assign len64    = 64'(len_bits);

   always_ff @(posedge wb_clk_i) begin
      if (!reset_n) begin
         state_q <= ST_DATA;
         wcnt_q  <= 4'd0;
         bcnt_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         bcnt_q  <= bcnt_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      bcnt_d    = bcnt_q;
      busy_d    = busy_q;
      out_valid = 1'b0;
      in_ready  = 1'b0;
      out_data  = 32'h0000_0000;

      case (state_q)
         ST_DATA: begin
            out_valid = in_valid;
            in_ready  = out_ready;
            out_data  = in_last ? pad_last_word(in_data, in_bytes) : in_data;
            if (in_valid && out_ready) begin
               busy_d = 1'b1;
               wcnt_d = wcnt_inc;
               if (in_last) begin
                  bcnt_d = bcnt_q + BCNT_W'(in_bytes);
                  // A full last word leaves no room for 0x80, so it gets its own word.
                  if (in_bytes >= 3'd4) begin
                     state_d = ST_PAD;
                  end else if (wcnt_inc == WCNT_LEN_HI) begin
                     state_d = ST_LEN_HI;
                  end else begin
                     state_d = ST_ZERO;
                  end
               end else begin
                  bcnt_d = bcnt_q + BCNT_W'(4);
               end
            end
         end

         ST_PAD: begin
            out_valid = 1'b1;
            out_data  = PAD_WORD;
            if (out_ready) begin
               wcnt_d  = wcnt_inc;
               state_d = (wcnt_inc == WCNT_LEN_HI) ? ST_LEN_HI : ST_ZERO;
            end
         end

         ST_ZERO: begin
            out_valid = 1'b1;
            if (out_ready) begin
               wcnt_d = wcnt_inc;
               if (wcnt_inc == WCNT_LEN_HI) begin
                  state_d = ST_LEN_HI;
               end
            end
         end

         ST_LEN_HI: begin
            out_valid = 1'b1;
            out_data  = len64[63:32];
            if (out_ready) begin
               wcnt_d  = wcnt_inc;
               state_d = ST_LEN_LO;
            end
         end

         ST_LEN_LO: begin
            out_valid = 1'b1;
            out_data  = len64[31:0];
            if (out_ready) begin
               wcnt_d  = 4'd0;
               bcnt_d  = '0;
               busy_d  = 1'b0;
               state_d = ST_DATA;
            end
         end

         default: begin
            state_d = ST_DATA;
         end
      endcase
   end

   assign out_blk_last = (wcnt_q == WCNT_LAST);
   assign out_msg_last = (state_q == ST_LEN_LO);
   assign busy         = busy_q;
   assign dbg_state_o  = state_q;

endmodule
